// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched on acceptance; the result is written on the edge that ends the last busy cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMultu = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpDivu  = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // op bit 0 marks the signed variants, bit 1 marks divide
  logic               op_signed;
  logic               op_is_div;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0]   abs_a, abs_b, quot_mag, rem_mag, quot, rem;
  logic               div_by_zero;

  assign op_signed = op_q[0];
  assign op_is_div = op_q[1];

  // Truncating a product of sign-extended operands gives the two's-complement result.
  assign mul_a = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_b = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes through the shared unsigned divider.
  assign abs_a       = (op_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b       = (op_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign div_by_zero = (b_q == '0);
  assign quot_mag    = div_by_zero ? '0 : abs_a / abs_b;
  assign rem_mag     = div_by_zero ? '0 : abs_a % abs_b;
  assign quot        = (op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot_mag : quot_mag;
  assign rem         = (op_signed && a_q[WIDTH-1]) ? -rem_mag : rem_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMultu, OpMult: begin
              a_d     = A;
              b_d     = B;
              op_d    = op[1:0];
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            OpDivu, OpDiv: begin
              a_d     = A;
              b_d     = B;
              op_d    = op[1:0];
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (op_is_div) begin
            if (!div_by_zero) begin
              hi_d = rem;
              lo_d = quot;
            end
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
